// File: rtl/regfile.sv
// Architectural register file with per-register ROB rename tags for the Tomasulo core.
// Optional macro REGFILE_BYPASS_EN forwards a same-cycle matching commit to the read ports.
module regfile #(
    parameter int ROB_W   = 4,
    parameter int REG_CNT = 32
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             rdy_in,
    input  logic             rob_clear,
    input  logic             is_commit,
    input  logic [4:0]       set_id,
    input  logic [31:0]      set_val,
    input  logic [ROB_W-1:0] set_from_rob_id,
    input  logic [4:0]       set_dep_id,
    input  logic [ROB_W-1:0] set_dep_Q,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    output logic [ROB_W-1:0] get_rob_id_1,
    output logic [ROB_W-1:0] get_rob_id_2,
    input  logic             rob_avail_1,
    input  logic             rob_avail_2,
    input  logic [31:0]      rob_val_1,
    input  logic [31:0]      rob_val_2,
    output logic [31:0]      val1,
    output logic [31:0]      val2,
    output logic             has_dep1,
    output logic             has_dep2,
    output logic [ROB_W-1:0] dep1,
    output logic [ROB_W-1:0] dep2
);

    logic [REG_CNT-1:0][31:0]      val_q;
    logic [REG_CNT-1:0][31:0]      val_d;
    logic [REG_CNT-1:0]            busy_q;
    logic [REG_CNT-1:0]            busy_d;
    logic [REG_CNT-1:0][ROB_W-1:0] dep_q;
    logic [REG_CNT-1:0][ROB_W-1:0] dep_d;

    logic [4:0]       rd_idx_s     [2];
    logic             rd_avail_s   [2];
    logic [31:0]      rd_rob_val_s [2];
    logic             rd_fwd_s     [2];
    logic [31:0]      rd_val_s     [2];
    logic             rd_has_s     [2];
    logic [ROB_W-1:0] rd_dep_s     [2];
    logic [ROB_W-1:0] rd_tag_s     [2];

    // Next-state: flush, commit write-back and issue-time rename tagging.
    always_comb begin
        val_d  = val_q;
        busy_d = busy_q;
        dep_d  = dep_q;
        if (rdy_in) begin
            if (rob_clear) begin
                busy_d = '0;
                dep_d  = '0;
            end else begin
                if (is_commit && (set_id != 5'd0)) begin
                    val_d[set_id] = set_val;
                    // Only the newest writer of a register may release it.
                    if (busy_q[set_id] && (dep_q[set_id] == set_from_rob_id)) begin
                        busy_d[set_id] = 1'b0;
                    end else begin
                        busy_d[set_id] = busy_q[set_id];
                    end
                end else begin
                    val_d = val_q;
                end
                if (set_dep_id != 5'd0) begin
                    busy_d[set_dep_id] = 1'b1;
                    dep_d[set_dep_id]  = set_dep_Q;
                end else begin
                    dep_d = dep_d;
                end
            end
        end else begin
            val_d  = val_q;
            busy_d = busy_q;
            dep_d  = dep_q;
        end
    end

    // State registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            val_q  <= '0;
            busy_q <= '0;
            dep_q  <= '0;
        end else begin
            val_q  <= val_d;
            busy_q <= busy_d;
            dep_q  <= dep_d;
        end
    end

    assign rd_idx_s[0]     = rs1_id;
    assign rd_idx_s[1]     = rs2_id;
    assign rd_avail_s[0]   = rob_avail_1;
    assign rd_avail_s[1]   = rob_avail_2;
    assign rd_rob_val_s[0] = rob_val_1;
    assign rd_rob_val_s[1] = rob_val_2;

    // Operand resolution for both read ports from pre-edge state.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_tag_s[p] = dep_q[rd_idx_s[p]];
            rd_val_s[p] = 32'd0;
            rd_has_s[p] = 1'b0;
            rd_dep_s[p] = '0;
`ifdef REGFILE_BYPASS_EN
            rd_fwd_s[p] = is_commit && (set_id == rd_idx_s[p]) &&
                          (dep_q[rd_idx_s[p]] == set_from_rob_id);
`else
            rd_fwd_s[p] = 1'b0;
`endif
            if (rd_idx_s[p] == 5'd0) begin
                rd_val_s[p] = 32'd0;
            end else if (!busy_q[rd_idx_s[p]]) begin
                rd_val_s[p] = val_q[rd_idx_s[p]];
            end else if (rd_fwd_s[p]) begin
                rd_val_s[p] = set_val;
            end else if (rd_avail_s[p]) begin
                rd_val_s[p] = rd_rob_val_s[p];
            end else begin
                rd_has_s[p] = 1'b1;
                rd_dep_s[p] = dep_q[rd_idx_s[p]];
            end
        end
    end

    assign get_rob_id_1 = rd_tag_s[0];
    assign get_rob_id_2 = rd_tag_s[1];
    assign val1         = rd_val_s[0];
    assign val2         = rd_val_s[1];
    assign has_dep1     = rd_has_s[0];
    assign has_dep2     = rd_has_s[1];
    assign dep1         = rd_dep_s[0];
    assign dep2         = rd_dep_s[1];

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios followed by randomized traffic
// checked against an array-based reference model.
module tb_regfile;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        rob_clear;
    logic        is_commit;
    logic [4:0]  set_id;
    logic [31:0] set_val;
    logic [3:0]  set_from_rob_id;
    logic [4:0]  set_dep_id;
    logic [3:0]  set_dep_Q;
    logic [4:0]  rs1_id;
    logic [4:0]  rs2_id;
    logic [3:0]  get_rob_id_1;
    logic [3:0]  get_rob_id_2;
    logic        rob_avail_1;
    logic        rob_avail_2;
    logic [31:0] rob_val_1;
    logic [31:0] rob_val_2;
    logic [31:0] val1;
    logic [31:0] val2;
    logic        has_dep1;
    logic        has_dep2;
    logic [3:0]  dep1;
    logic [3:0]  dep2;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_val  [32];
    logic        m_busy [32];
    logic [3:0]  m_dep  [32];

    regfile #(.ROB_W(4), .REG_CNT(32)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
        .is_commit(is_commit), .set_id(set_id), .set_val(set_val),
        .set_from_rob_id(set_from_rob_id), .set_dep_id(set_dep_id), .set_dep_Q(set_dep_Q),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .get_rob_id_1(get_rob_id_1), .get_rob_id_2(get_rob_id_2),
        .rob_avail_1(rob_avail_1), .rob_avail_2(rob_avail_2),
        .rob_val_1(rob_val_1), .rob_val_2(rob_val_2),
        .val1(val1), .val2(val2), .has_dep1(has_dep1), .has_dep2(has_dep2),
        .dep1(dep1), .dep2(dep2)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_val[i]  = 32'd0;
            m_busy[i] = 1'b0;
            m_dep[i]  = 4'd0;
        end
    endtask

    task automatic idle();
        rdy_in = 1'b1; rob_clear = 1'b0; is_commit = 1'b0;
        set_id = 5'd0; set_val = 32'd0; set_from_rob_id = 4'd0;
        set_dep_id = 5'd0; set_dep_Q = 4'd0;
        rs1_id = 5'd0; rs2_id = 5'd0;
        rob_avail_1 = 1'b0; rob_avail_2 = 1'b0; rob_val_1 = 32'd0; rob_val_2 = 32'd0;
    endtask

    // Advance one clock; the model applies the architectural rules to the inputs held at the edge.
    task automatic cyc();
        @(posedge clk_in);
        if (!rst_n_in) begin
            model_reset();
        end else if (rdy_in) begin
            if (rob_clear) begin
                for (int i = 0; i < 32; i++) begin
                    m_busy[i] = 1'b0;
                    m_dep[i]  = 4'd0;
                end
            end else begin
                if (is_commit && set_id != 5'd0) begin
                    m_val[set_id] = set_val;
                    if (m_busy[set_id] && m_dep[set_id] == set_from_rob_id) m_busy[set_id] = 1'b0;
                end
                if (set_dep_id != 5'd0) begin
                    m_busy[set_dep_id] = 1'b1;
                    m_dep[set_dep_id]  = set_dep_Q;
                end
            end
        end
        #1;
    endtask

    function automatic void exp_read(input logic [4:0] r, input logic avail, input logic [31:0] rv,
                                     output logic [31:0] v, output logic h,
                                     output logic [3:0] d, output logic [3:0] gid);
        gid = m_dep[r];
        v = 32'd0; h = 1'b0; d = 4'd0;
        if (r == 5'd0) begin
            v = 32'd0;
        end else if (!m_busy[r]) begin
            v = m_val[r];
`ifdef REGFILE_BYPASS_EN
        end else if (is_commit && set_id == r && m_dep[r] == set_from_rob_id) begin
            v = set_val;
`endif
        end else if (avail) begin
            v = rv;
        end else begin
            h = 1'b1;
            d = m_dep[r];
        end
    endfunction

    task automatic chk_ports(input string tag);
        logic [31:0] v;
        logic        h;
        logic [3:0]  d;
        logic [3:0]  g;
        #1;
        exp_read(rs1_id, rob_avail_1, rob_val_1, v, h, d, g);
        chk({tag, "_val1"}, val1, v);
        chk({tag, "_has1"}, {31'd0, has_dep1}, {31'd0, h});
        chk({tag, "_dep1"}, {28'd0, dep1}, {28'd0, d});
        chk({tag, "_gid1"}, {28'd0, get_rob_id_1}, {28'd0, g});
        exp_read(rs2_id, rob_avail_2, rob_val_2, v, h, d, g);
        chk({tag, "_val2"}, val2, v);
        chk({tag, "_has2"}, {31'd0, has_dep2}, {31'd0, h});
        chk({tag, "_dep2"}, {28'd0, dep2}, {28'd0, d});
        chk({tag, "_gid2"}, {28'd0, get_rob_id_2}, {28'd0, g});
    endtask

    task automatic set_dep(input logic [4:0] r, input logic [3:0] q);
        idle(); set_dep_id = r; set_dep_Q = q; cyc();
    endtask

    task automatic commit(input logic [4:0] r, input logic [31:0] v, input logic [3:0] q);
        idle(); is_commit = 1'b1; set_id = r; set_val = v; set_from_rob_id = q; cyc();
    endtask

    initial begin
        model_reset();
        idle();
        rst_n_in = 1'b0;
        repeat (3) cyc();
        rs1_id = 5'd5;
        chk_ports("reset");
        chk("reset_val1_k", val1, 32'd0);
        rst_n_in = 1'b1;
        cyc();

        // Rename x5 to tag 3, then resolve through the ROB bypass path.
        set_dep(5'd5, 4'd3);
        rs1_id = 5'd5; rob_avail_1 = 1'b0;
        chk_ports("s2");
        chk("s2_dep1_k", {28'd0, dep1}, 32'd3);
        chk("s2_has1_k", {31'd0, has_dep1}, 32'd1);
        rob_avail_1 = 1'b1; rob_val_1 = 32'h1234;
        chk_ports("s3");
        chk("s3_val1_k", val1, 32'h1234);

        // Older commit must not release a register renamed again by a younger writer.
        set_dep(5'd5, 4'd7);
        commit(5'd5, 32'hAA, 4'd3);
        idle(); rs1_id = 5'd5;
        chk_ports("s4a");
        chk("s4a_dep1_k", {28'd0, dep1}, 32'd7);
        commit(5'd5, 32'hBB, 4'd7);
        idle(); rs1_id = 5'd5;
        chk_ports("s4b");
        chk("s4b_val1_k", val1, 32'hBB);

        // Commit and issue to x6 in the same cycle.
        set_dep(5'd6, 4'd2);
        idle(); is_commit = 1'b1; set_id = 5'd6; set_val = 32'h11; set_from_rob_id = 4'd2;
        set_dep_id = 5'd6; set_dep_Q = 4'd4; rs1_id = 5'd6; rs2_id = 5'd6;
        chk_ports("s5_pre");
        cyc();
        idle(); rs1_id = 5'd6;
        chk_ports("s5");
        chk("s5_dep1_k", {28'd0, dep1}, 32'd4);

        // Flush discards the same-cycle issue and keeps values.
        set_dep(5'd1, 4'd1);
        set_dep(5'd2, 4'd2);
        idle(); rob_clear = 1'b1; set_dep_id = 5'd3; set_dep_Q = 4'd5; cyc();
        idle(); rs1_id = 5'd6; rs2_id = 5'd3;
        chk_ports("s6a");
        chk("s6a_val1_k", val1, 32'h11);
        rs1_id = 5'd1; rs2_id = 5'd2;
        chk_ports("s6b");
        set_dep(5'd0, 4'd9);
        commit(5'd0, 32'hDEAD, 4'd0);
        idle(); rs1_id = 5'd0; rs2_id = 5'd0;
        chk_ports("x0");
        chk("x0_val1_k", val1, 32'd0);

        // Global enable low holds every piece of state.
        idle(); rdy_in = 1'b0; set_dep_id = 5'd9; set_dep_Q = 4'd6;
        is_commit = 1'b1; set_id = 5'd6; set_val = 32'h77; cyc();
        idle(); rs1_id = 5'd9; rs2_id = 5'd6;
        chk_ports("hold");

        // Randomized traffic with commit tags biased to hit the current rename tag.
        for (int n = 0; n < 400; n++) begin
            idle();
            rdy_in          = ($urandom_range(0, 7) != 0);
            rob_clear       = ($urandom_range(0, 24) == 0);
            is_commit       = $urandom_range(0, 1) == 1;
            set_id          = 5'($urandom_range(0, 7));
            set_val         = $urandom;
            set_from_rob_id = ($urandom_range(0, 1) == 1) ? m_dep[set_id] : 4'($urandom_range(0, 15));
            set_dep_id      = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 7)) : 5'd0;
            set_dep_Q       = 4'($urandom_range(0, 15));
            rs1_id          = 5'($urandom_range(0, 7));
            rs2_id          = 5'($urandom_range(0, 7));
            rob_avail_1     = $urandom_range(0, 2) == 0;
            rob_avail_2     = $urandom_range(0, 2) == 0;
            rob_val_1       = $urandom;
            rob_val_2       = $urandom;
            chk_ports($sformatf("rnd%0d", n));
            cyc();
        end

        // Asynchronous reset lands mid-commit and clears state immediately.
        idle(); rs1_id = 5'd6; rs2_id = 5'd1;
        is_commit = 1'b1; set_id = 5'd6; set_val = 32'h55; set_from_rob_id = m_dep[6];
        #2;
        rst_n_in = 1'b0;
        model_reset();
        chk_ports("async_rst");
        chk("async_rst_val1_k", val1, 32'd0);
        cyc();
        rst_n_in = 1'b1;
        idle(); rs1_id = 5'd6;
        chk_ports("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
